npu_cube_acc_resolve: RTL and testbench
=======================================

Name: npu_cube_acc_resolve

Overview:
- Consumes the level-7 carry-save pair (l7_linecay0/l7_linesum0) from the final CUBE adder-tree stage.
- Resolves the pair to binary with a carry-propagate adder.
- Accumulates resolved partial products over a multi-beat group (K-dimension passes).
- Presents one accumulated result per group to the writeback path through a valid/ready handshake.

Parameters:
- DWIN, 19, width of each carry-save input word.
- DWRES, 21, resolved width, DWIN+2.
- DWACC, 32, accumulator and output width; must be at least DWRES.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat available.
- in_ready  output  1  block accepts a beat this cycle.
- in_first  input  1  beat starts a new group.
- in_last  input  1  beat ends the group.
- in_carry  input  DWIN  carry vector, weight 2 (from l7_linecay0).
- in_sum  input  DWIN  sum vector, weight 1 (from l7_linesum0).
- out_valid  output  1  accumulated result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  DWACC  accumulated group result.
- out_ovf  output  1  accumulator wrapped during this group.
- out_err  output  1  protocol error occurred in this group.
- busy  output  1  group open or pipeline non-empty.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid, out_data, out_ovf, out_err, busy, all pipeline valids, accumulator and sticky flags go to 0.
  - FSM goes to IDLE.
  - in_ready=1 from the first clock after release.
- Advance condition: adv = ~out_valid | out_ready. in_ready = adv. All stages shift together only when adv=1 (global stall, no bubbles squeezed).
- Stage 1 (resolve), on accepted beat:
  - r1 = zero-extended in_sum + (in_carry << 1), DWRES bits, unsigned.
  - first/last/valid flags are registered alongside r1.
- Stage 2 (accumulate), on valid stage-1 beat:
  - acc = (start ? 0 : acc) + zext(r1), DWACC bits, modulo 2^DWACC.
  - A carry out of bit DWACC-1 sets sticky ovf.
- FSM, evaluated at stage 2:
  - IDLE + beat with first=1 -> ACC, start=1, clears ovf/err.
  - IDLE + beat with first=0 -> ACC, start=1, err set (orphan beat treated as first).
  - ACC + beat with first=1 -> stays ACC, start=1, err set (previous group discarded; err belongs to new group).
  - ACC + beat with first=0 -> stays ACC, start=0.
  - Any state + beat with last=1 -> result loaded to output register, state -> IDLE.
  - first=1 and last=1 on the same beat is a legal single-beat group.
- Output register:
  - Loads out_data/out_ovf/out_err and sets out_valid on stage-2 last.
  - Holds stable while out_valid & ~out_ready.
  - Clears out_valid on out_ready unless reloaded the same cycle.
- Latency: beat with last accepted in cycle N -> out_valid=1 in cycle N+2. Throughput: one beat per cycle with out_ready held at 1.
- Simultaneous out_ready and new stage-2 last: result is replaced the same cycle; no result is dropped.
- busy = (state==ACC) | stage-1 valid | stage-2 valid.
- in_valid & ~in_ready: the beat is not consumed. The upstream holds in_* stable (hold is the upstream's obligation; not checked here).

Decomposition:
- Shared package npu_cube_pkg holds:
  - constants DWIN/DWRES/DWACC defaults;
  - FSM state enum (IDLE, ACC);
  - beat-flag struct (valid, first, last).
- Sub-module npu_cube_cs_resolve: registered carry-save to binary adder (stage 1), with enable input adv.
- Top level holds the FSM, accumulator and output register.

Test Plan:
- Single beat, first=last=1, sum=0x00005, carry=0x00003, out_ready=1 -> out_data=11 in cycle N+2, ovf=0, err=0.
- Four-beat group, each sum=0x7FFFF and carry=0x7FFFF (resolved value 0x17FFFD) -> out_data=0x5FFFF4, single out_valid pulse.
- Back-pressure: two back-to-back single-beat groups with values 1 and 2, out_ready=0 for 5 cycles -> in_ready=0 while stalled, out_data holds 1; release -> 1 then 2 delivered, none lost.
- Wrap, with DWACC=21 overridden:
  - 2-beat group of resolved 0x180000 each -> out_data=0x100000, out_ovf=1;
  - next group resolving to 5 -> out_ovf=0.
- Protocol errors:
  - beat with first=0 in IDLE (value 7, last=1) -> out_data=7, out_err=1;
  - first=1 mid-group -> prior partial is discarded and the result carries err=1.
- Reset mid-group: assert rst_n=0 after 2 of 4 beats -> all outputs 0 immediately; after release, new group value 9 -> out_data=9, err=0.

Source files
------------

// File: rtl/npu_cube_pkg.sv
// Shared definitions for the CUBE accumulate/resolve slice: default widths,
// accumulator FSM states and the per-beat flag bundle carried down the pipe.
package npu_cube_pkg;

    localparam int DWIN_DEF  = 19;
    localparam int DWRES_DEF = 21;
    localparam int DWACC_DEF = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_flags_t;

endpackage

// File: rtl/npu_cube_cs_resolve.sv
// Stage 1: registered carry-save to binary resolve. The carry vector has
// weight 2, so it is shifted left by one before the carry-propagate add.
module npu_cube_cs_resolve
    import npu_cube_pkg::*;
#(
    parameter int DWIN  = DWIN_DEF,
    parameter int DWRES = DWRES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  beat_flags_t       in_flags,
    input  logic [DWIN-1:0]   in_carry,
    input  logic [DWIN-1:0]   in_sum,
    output beat_flags_t       out_flags,
    output logic [DWRES-1:0]  out_res
);

    beat_flags_t      flags_q, flags_d;
    logic [DWRES-1:0] res_q, res_d;

    // Next-state for the stage register: shift on adv, hold during stall.
    always_comb begin
        flags_d = flags_q;
        res_d   = res_q;
        if (adv) begin
            flags_d = in_flags;
            if (in_flags.valid) begin
                res_d = DWRES'(in_sum) + DWRES'({in_carry, 1'b0});
            end else begin
                res_d = res_q;
            end
        end else begin
            flags_d = flags_q;
            res_d   = res_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '{valid: 1'b0, first: 1'b0, last: 1'b0};
            res_q   <= '0;
        end else begin
            flags_q <= flags_d;
            res_q   <= res_d;
        end
    end

    assign out_flags = flags_q;
    assign out_res   = res_q;

endmodule

// File: rtl/npu_cube_acc_resolve.sv
// Resolves the final adder-tree carry-save pair, accumulates it across the
// beats of a K-group and hands one result per group to writeback.
module npu_cube_acc_resolve
    import npu_cube_pkg::*;
#(
    parameter int DWIN  = DWIN_DEF,
    parameter int DWRES = DWRES_DEF,
    parameter int DWACC = DWACC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [DWIN-1:0]  in_carry,
    input  logic [DWIN-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DWACC-1:0] out_data,
    output logic             out_ovf,
    output logic             out_err,
    output logic             busy
);

    acc_state_e       state_q, state_d;
    beat_flags_t      in_flags_s, s1_flags_s;
    logic [DWRES-1:0] s1_res_s;
    logic             adv_s;
    logic             rdy_en_q, rdy_en_d;
    logic             s2_valid_q, s2_valid_d;
    logic [DWACC-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [DWACC-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_err_q, out_err_d;
    logic             beat_s, start_s, err_set_s;
    logic [DWACC-1:0] base_s;
    logic [DWACC:0]   sum_s;
    logic             ovf_new_s, err_new_s;

    // Global stall: the whole pipe moves only when the output slot can take a result.
    assign adv_s      = ~out_valid_q | out_ready;
    assign in_ready   = rdy_en_q & adv_s;
    assign in_flags_s = '{valid: in_valid & in_ready, first: in_first, last: in_last};
    assign rdy_en_d   = 1'b1;

    npu_cube_cs_resolve #(
        .DWIN  (DWIN),
        .DWRES (DWRES)
    ) u_resolve (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (adv_s),
        .in_flags  (in_flags_s),
        .in_carry  (in_carry),
        .in_sum    (in_sum),
        .out_flags (s1_flags_s),
        .out_res   (s1_res_s)
    );

    // Stage-2 beat decode: a group restarts on IDLE or on a fresh first.
    always_comb begin
        beat_s  = adv_s & s1_flags_s.valid;
        start_s = (state_q == IDLE) | s1_flags_s.first;
        if (state_q == IDLE) begin
            err_set_s = ~s1_flags_s.first;
        end else begin
            err_set_s = s1_flags_s.first;
        end
        if (start_s) begin
            base_s = '0;
        end else begin
            base_s = acc_q;
        end
        sum_s     = {1'b0, base_s} + (DWACC+1)'(s1_res_s);
        ovf_new_s = (start_s ? 1'b0 : ovf_q) | sum_s[DWACC];
        err_new_s = (start_s ? 1'b0 : err_q) | err_set_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: any consumed beat opens a group, a last beat closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: begin
                if (beat_s) begin
                    state_d = s1_flags_s.last ? IDLE : ACC;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: accumulator, sticky flags and the result slot.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_err_d   = out_err_q;
        if (adv_s) begin
            s2_valid_d = s1_flags_s.valid;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (beat_s) begin
            acc_d = sum_s[DWACC-1:0];
            ovf_d = ovf_new_s;
            err_d = err_new_s;
        end else begin
            acc_d = acc_q;
        end
        // A new result may replace one being taken this same cycle.
        if (beat_s && s1_flags_s.last) begin
            out_valid_d = 1'b1;
            out_data_d  = sum_s[DWACC-1:0];
            out_ovf_d   = ovf_new_s;
            out_err_d   = err_new_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            rdy_en_q    <= rdy_en_d;
            s2_valid_q  <= s2_valid_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q == ACC) | s1_flags_s.valid | s2_valid_q;

endmodule

// File: tb/tb_npu_cube_acc_resolve.sv
// Bench: two instances (32-bit and 21-bit accumulator) share one stimulus
// stream; a group-level model predicts every delivered result.
module tb_npu_cube_acc_resolve;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_first, in_last, out_ready;
    logic [18:0] in_carry, in_sum;
    logic        in_ready_a, out_valid_a, out_ovf_a, out_err_a, busy_a;
    logic [31:0] out_data_a;
    logic        in_ready_b, out_valid_b, out_ovf_b, out_err_b, busy_b;
    logic [20:0] out_data_b;

    npu_cube_acc_resolve dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_first(in_first), .in_last(in_last), .in_carry(in_carry), .in_sum(in_sum),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_ovf(out_ovf_a), .out_err(out_err_a), .busy(busy_a));

    npu_cube_acc_resolve #(.DWACC(21)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_first(in_first), .in_last(in_last), .in_carry(in_carry), .in_sum(in_sum),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_ovf(out_ovf_b), .out_err(out_err_b), .busy(busy_b));

    typedef struct {
        longint data;
        bit     ovf;
        bit     err;
    } res_t;

    res_t   q_a[$];
    res_t   q_b[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     open_m[2];
    longint total_m[2];
    bit     err_m[2];
    longint last_data[2];
    bit     last_ovf[2];
    bit     last_err[2];
    int     n_deliv[2];
    bit     rand_ready = 1'b0;

    task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Group-level reference: a group's result is the plain sum of its beats.
    task automatic model_accept(bit first, bit last, longint r);
        res_t   res;
        int     w;
        longint mask;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 32 : 21;
            mask = (longint'(1) << w) - 1;
            if (!open_m[k]) begin
                total_m[k] = r;
                err_m[k]   = !first;
            end else if (first) begin
                total_m[k] = r;
                err_m[k]   = 1'b1;
            end else begin
                total_m[k] = total_m[k] + r;
            end
            open_m[k] = 1'b1;
            if (last) begin
                res.data = total_m[k] & mask;
                res.ovf  = (total_m[k] >> w) != 0;
                res.err  = err_m[k];
                if (k == 0) q_a.push_back(res);
                else        q_b.push_back(res);
                open_m[k] = 1'b0;
            end
        end
    endtask

    task automatic deliver(int k, logic [63:0] data, bit ovf, bit err);
        res_t exp;
        int   sz;
        sz = (k == 0) ? q_a.size() : q_b.size();
        check_eq($sformatf("result_expected_%0d", k), 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            if (k == 0) exp = q_a.pop_front();
            else        exp = q_b.pop_front();
            check_eq($sformatf("data_%0d", k), data, 64'(exp.data));
            check_eq($sformatf("ovf_%0d", k), 64'(ovf), 64'(exp.ovf));
            check_eq($sformatf("err_%0d", k), 64'(err), 64'(exp.err));
        end
        last_data[k] = longint'(data);
        last_ovf[k]  = ovf;
        last_err[k]  = err;
        n_deliv[k]++;
    endtask

    // One clock: sample handshakes, update scoreboard/model, advance the edge.
    task automatic step(output bit accepted);
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = in_valid && in_ready_a;
        if (out_valid_a && out_ready) deliver(0, 64'(out_data_a), out_ovf_a, out_err_a);
        if (out_valid_b && out_ready) deliver(1, 64'(out_data_b), out_ovf_b, out_err_b);
        if (accepted) model_accept(in_first, in_last, longint'(in_sum) + 2 * longint'(in_carry));
        @(posedge clk);
        #1;
    endtask

    task automatic send(bit first, bit last, logic [18:0] s, logic [18:0] c);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_sum   = s;
        in_carry = c;
        for (int t = 0; t < 64 && !done; t++) step(done);
        check_eq("beat_accepted", 64'(done), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(int n);
        bit d;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(d);
    endtask

    task automatic drain();
        bit d;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        for (int t = 0; t < 100 && (q_a.size() + q_b.size()) != 0; t++) step(d);
        check_eq("drain_empty", 64'(q_a.size() + q_b.size()), 64'd0);
        idle(3);
        check_eq("drain_busy", 64'(busy_a), 64'd0);
    endtask

    task automatic check_zero(string tag);
        check_eq({tag, "_valid"}, 64'(out_valid_a), 64'd0);
        check_eq({tag, "_data"},  64'(out_data_a),  64'd0);
        check_eq({tag, "_ovf"},   64'(out_ovf_a),   64'd0);
        check_eq({tag, "_err"},   64'(out_err_a),   64'd0);
        check_eq({tag, "_busy"},  64'(busy_a),      64'd0);
        check_eq({tag, "_data_b"}, 64'(out_data_b), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit d;
        int pulses;
        int base;
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_sum = '0; in_carry = '0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            open_m[k] = 1'b0; n_deliv[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        step(d);
        check_eq("ready_after_reset", 64'(in_ready_a), 64'd1);

        // Single-beat group and its two-cycle latency.
        send(1'b1, 1'b1, 19'h00005, 19'h00003);
        check_eq("lat_n1_valid", 64'(out_valid_a), 64'd0);
        idle(1);
        check_eq("lat_n2_valid", 64'(out_valid_a), 64'd1);
        check_eq("single_data", 64'(out_data_a), 64'd11);
        check_eq("single_ovf", 64'(out_ovf_a), 64'd0);
        check_eq("single_err", 64'(out_err_a), 64'd0);
        idle(1);
        check_eq("single_pulse_end", 64'(out_valid_a), 64'd0);

        // Four-beat group at maximum input values.
        for (int b = 0; b < 4; b++) send(b == 0, b == 3, 19'h7FFFF, 19'h7FFFF);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(d);
            if (out_valid_a) pulses++;
        end
        check_eq("four_pulses", 64'(pulses), 64'd1);
        check_eq("four_data", 64'(last_data[0]), 64'h5FFFF4);
        check_eq("four_data_b", 64'(last_data[1]), 64'h1FFFF4);
        check_eq("four_ovf_b", 64'(last_ovf[1]), 64'd1);

        // Back-pressure with two single-beat groups queued behind the slot.
        out_ready = 1'b0;
        base = n_deliv[0];
        send(1'b1, 1'b1, 19'd1, 19'd0);
        send(1'b1, 1'b1, 19'd2, 19'd0);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ready_low", 64'(in_ready_a), 64'd0);
            check_eq("bp_hold_data", 64'(out_data_a), 64'd1);
            step(d);
        end
        out_ready = 1'b1;
        idle(3);
        check_eq("bp_delivered", 64'(n_deliv[0] - base), 64'd2);
        check_eq("bp_last", 64'(last_data[0]), 64'd2);

        // Wrap in the narrow accumulator, then a clean group clears ovf.
        send(1'b1, 1'b0, 19'h7FFFF, 19'h7FFFF);
        send(1'b0, 1'b1, 19'h7FFFF, 19'h7FFFF);
        idle(3);
        check_eq("wrap_data_b", 64'(last_data[1]), 64'hFFFFA);
        check_eq("wrap_ovf_b", 64'(last_ovf[1]), 64'd1);
        check_eq("wrap_ovf_a", 64'(last_ovf[0]), 64'd0);
        send(1'b1, 1'b1, 19'd5, 19'd0);
        idle(3);
        check_eq("post_wrap_data_b", 64'(last_data[1]), 64'd5);
        check_eq("post_wrap_ovf_b", 64'(last_ovf[1]), 64'd0);

        // Protocol errors: orphan beat, then a restart mid-group.
        send(1'b0, 1'b1, 19'd7, 19'd0);
        idle(3);
        check_eq("orphan_data", 64'(last_data[0]), 64'd7);
        check_eq("orphan_err", 64'(last_err[0]), 64'd1);
        send(1'b1, 1'b0, 19'd100, 19'd0);
        send(1'b1, 1'b0, 19'd20, 19'd0);
        send(1'b0, 1'b1, 19'd3, 19'd0);
        idle(3);
        check_eq("restart_data", 64'(last_data[0]), 64'd23);
        check_eq("restart_err", 64'(last_err[0]), 64'd1);
        send(1'b1, 1'b1, 19'd4, 19'd0);
        idle(3);
        check_eq("clean_err", 64'(last_err[0]), 64'd0);

        // Reset in the middle of a four-beat group.
        send(1'b1, 1'b0, 19'd1, 19'd1);
        send(1'b0, 1'b0, 19'd1, 19'd1);
        check_eq("busy_mid_group", 64'(busy_a), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        for (int k = 0; k < 2; k++) open_m[k] = 1'b0;
        q_a.delete();
        q_b.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(d);
        check_eq("midrst_ready", 64'(in_ready_a), 64'd1);
        send(1'b1, 1'b1, 19'd9, 19'd0);
        idle(3);
        check_eq("midrst_data", 64'(last_data[0]), 64'd9);
        check_eq("midrst_err", 64'(last_err[0]), 64'd0);

        // Random groups with random back-pressure and gaps.
        rand_ready = 1'b1;
        for (int g = 0; g < 80; g++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                bit f;
                f = (b == 0);
                if ($urandom_range(0, 9) == 0) f = ~f;
                send(f, b == len - 1, 19'($urandom), 19'($urandom));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
